// File: rtl/pfn_buf_pkg.sv
// Shared types and helpers for the multi-channel hot-PFN buffer.
// Status struct fields are sized for the largest configuration; consumers slice.
package pfn_buf_pkg;

    typedef enum logic {
        MODE_STOP = 1'b0,
        MODE_WRAP = 1'b1
    } mode_e;

    localparam int STAT_W = 32;

    typedef struct packed {
        logic [STAT_W-1:0] wr_ptr;
        logic [STAT_W-1:0] wr_cnt;
        logic              full;
        logic              wrapped;
        logic              ovf_sticky;
        logic [STAT_W-1:0] ovf_cnt;
    } pfn_chan_status_t;

    // Index width with a floor of one bit, so a single-channel build still has a select port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pfn_chan_buf.sv
// One channel: simple dual-port RAM (registered read, 1 cycle) plus write pointer, fill count and overflow tracking.
// Never stalls: writes into a full channel are dropped or overwrite the oldest entry depending on mode_wrap.
module pfn_chan_buf
    import pfn_buf_pkg::*;
#(
    parameter int NUM_ENTRIES   = 1024,
    parameter int ENTRY_WIDTH   = 32,
    parameter int OVF_CNT_WIDTH = 16,
    parameter int IDX_W         = clog2_min1(NUM_ENTRIES)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     mode_wrap,
    input  logic                     wr_en,
    input  logic [ENTRY_WIDTH-1:0]   wr_data,
    input  logic                     wr_idx_rst,
    input  logic                     ovf_clr,
    input  logic                     rd_en,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [ENTRY_WIDTH-1:0]   rd_data,
    output logic [IDX_W-1:0]         wr_ptr,
    output logic [IDX_W:0]           wr_cnt,
    output logic                     full,
    output logic                     wrapped,
    output logic                     ovf_sticky,
    output logic [OVF_CNT_WIDTH-1:0] ovf_cnt
);

    localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(NUM_ENTRIES);

    mode_e mode;
    assign mode = mode_e'(mode_wrap);

    logic [ENTRY_WIDTH-1:0] mem [NUM_ENTRIES];

    logic [IDX_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]           wr_cnt_q, wr_cnt_d;
    logic                     wrapped_q, wrapped_d;
    logic                     ovf_sticky_q, ovf_sticky_d;
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [ENTRY_WIDTH-1:0]   rd_data_q;
    logic                     ram_we;
    logic [IDX_W-1:0]         ram_waddr;
    logic                     ovf_evt;
    logic                     is_full;

    assign is_full = (wr_cnt_q == CNT_FULL);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        wr_cnt_d     = wr_cnt_q;
        wrapped_d    = wrapped_q;
        ovf_sticky_d = ovf_sticky_q;
        ovf_cnt_d    = ovf_cnt_q;
        ram_we       = 1'b0;
        ram_waddr    = wr_ptr_q;
        ovf_evt      = 1'b0;

        // A pointer clear takes priority and turns a same-cycle write into the first entry.
        if (wr_idx_rst) begin
            wr_ptr_d  = '0;
            wr_cnt_d  = '0;
            wrapped_d = 1'b0;
            if (wr_en) begin
                ram_we    = 1'b1;
                ram_waddr = '0;
                wr_ptr_d  = IDX_W'(1);
                wr_cnt_d  = (IDX_W+1)'(1);
            end
        end else if (wr_en) begin
            if (!is_full) begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + IDX_W'(1);
                wr_cnt_d = wr_cnt_q + (IDX_W+1)'(1);
            end else if (mode == MODE_WRAP) begin
                ram_we    = 1'b1;
                wr_ptr_d  = wr_ptr_q + IDX_W'(1);
                wrapped_d = 1'b1;
                ovf_evt   = 1'b1;
            end else begin
                ovf_evt = 1'b1;
            end
        end

        // A clear coinciding with an event still records that event.
        if (ovf_clr) begin
            ovf_cnt_d    = ovf_evt ? OVF_CNT_WIDTH'(1) : '0;
            ovf_sticky_d = ovf_evt;
        end else if (ovf_evt) begin
            ovf_sticky_d = 1'b1;
            if (ovf_cnt_q != '1) begin
                ovf_cnt_d = ovf_cnt_q + OVF_CNT_WIDTH'(1);
            end
        end

        if (!reset_n) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            wr_cnt_q     <= '0;
            wrapped_q    <= 1'b0;
            ovf_sticky_q <= 1'b0;
            ovf_cnt_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_cnt_q     <= wr_cnt_d;
            wrapped_q    <= wrapped_d;
            ovf_sticky_q <= ovf_sticky_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    // RAM array is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign rd_data    = rd_data_q;
    assign wr_ptr     = wr_ptr_q;
    assign wr_cnt     = wr_cnt_q;
    assign full       = is_full;
    assign wrapped    = wrapped_q;
    assign ovf_sticky = ovf_sticky_q;
    assign ovf_cnt    = ovf_cnt_q;

endmodule

// File: rtl/pfn_multi_chan_buffer.sv
// NUM_CH independent hot-PFN buffers behind one pipelined read port; read data 2 cycles after rd_req.
// No backpressure anywhere: reads never stall writes, and full channels drop or overwrite per mode_wrap.
module pfn_multi_chan_buffer
    import pfn_buf_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int NUM_ENTRIES   = 1024,
    parameter int ENTRY_WIDTH   = 32,
    parameter int OVF_CNT_WIDTH = 16,
    parameter int IDX_W         = clog2_min1(NUM_ENTRIES),
    parameter int CH_W          = clog2_min1(NUM_CH)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  mode_wrap,
    input  logic [NUM_CH-1:0]                     wr_en,
    input  logic [NUM_CH-1:0][ENTRY_WIDTH-1:0]    pfn_addr_i,
    input  logic [NUM_CH-1:0]                     wr_idx_rst,
    input  logic [NUM_CH-1:0]                     ovf_clr,
    input  logic                                  rd_req,
    input  logic [CH_W-1:0]                       rd_ch,
    input  logic [IDX_W-1:0]                      rd_idx,
    output logic                                  rd_valid_o,
    output logic [ENTRY_WIDTH-1:0]                rd_data_o,
    output logic [NUM_CH-1:0][IDX_W-1:0]          wr_ptr_o,
    output logic [NUM_CH-1:0][IDX_W:0]            wr_cnt_o,
    output logic [NUM_CH-1:0]                     full_o,
    output logic [NUM_CH-1:0]                     wrapped_o,
    output logic [NUM_CH-1:0]                     ovf_sticky_o,
    output logic [NUM_CH-1:0][OVF_CNT_WIDTH-1:0]  ovf_cnt_o
);

    logic [NUM_CH-1:0]                  chan_rd_en;
    logic [NUM_CH-1:0][ENTRY_WIDTH-1:0] chan_rd_data;

    logic                   rd_vld_s1_q, rd_vld_s1_d;
    logic [CH_W-1:0]        rd_ch_s1_q, rd_ch_s1_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [ENTRY_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        chan_rd_en = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            chan_rd_en[c] = rd_req && (rd_ch == CH_W'(c));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        pfn_chan_buf #(
            .NUM_ENTRIES   (NUM_ENTRIES),
            .ENTRY_WIDTH   (ENTRY_WIDTH),
            .OVF_CNT_WIDTH (OVF_CNT_WIDTH),
            .IDX_W         (IDX_W)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .mode_wrap  (mode_wrap),
            .wr_en      (wr_en[g]),
            .wr_data    (pfn_addr_i[g]),
            .wr_idx_rst (wr_idx_rst[g]),
            .ovf_clr    (ovf_clr[g]),
            .rd_en      (chan_rd_en[g]),
            .rd_idx     (rd_idx),
            .rd_data    (chan_rd_data[g]),
            .wr_ptr     (wr_ptr_o[g]),
            .wr_cnt     (wr_cnt_o[g]),
            .full       (full_o[g]),
            .wrapped    (wrapped_o[g]),
            .ovf_sticky (ovf_sticky_o[g]),
            .ovf_cnt    (ovf_cnt_o[g])
        );
    end

    // Channel select travels alongside the RAM read so the mux picks the right bank a cycle later.
    always_comb begin
        rd_vld_s1_d = rd_req;
        rd_ch_s1_d  = rd_ch;
        rd_valid_d  = rd_vld_s1_q;
        rd_data_d   = rd_data_q;
        if (rd_vld_s1_q) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (rd_ch_s1_q == CH_W'(c)) begin
                    rd_data_d = chan_rd_data[c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_vld_s1_q <= 1'b0;
            rd_ch_s1_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rd_vld_s1_q <= rd_vld_s1_d;
            rd_ch_s1_q  <= rd_ch_s1_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_pfn_multi_chan_buffer.sv
// Directed bench for pfn_multi_chan_buffer: per-cycle comparison against a write-history model,
// plus hand-computed literal checks for each scenario.
module tb_pfn_multi_chan_buffer;
    import pfn_buf_pkg::*;

    localparam int NCH = 2;
    localparam int NE  = 8;
    localparam int EW  = 32;
    localparam int OW  = 4;
    localparam int IW  = 3;
    localparam int CW  = 1;

    logic                     clk;
    logic                     reset_n;
    logic                     mode_wrap;
    logic [NCH-1:0]           wr_en;
    logic [NCH-1:0][EW-1:0]   pfn_addr_i;
    logic [NCH-1:0]           wr_idx_rst;
    logic [NCH-1:0]           ovf_clr;
    logic                     rd_req;
    logic [CW-1:0]            rd_ch;
    logic [IW-1:0]            rd_idx;
    logic                     rd_valid_o;
    logic [EW-1:0]            rd_data_o;
    logic [NCH-1:0][IW-1:0]   wr_ptr_o;
    logic [NCH-1:0][IW:0]     wr_cnt_o;
    logic [NCH-1:0]           full_o;
    logic [NCH-1:0]           wrapped_o;
    logic [NCH-1:0]           ovf_sticky_o;
    logic [NCH-1:0][OW-1:0]   ovf_cnt_o;

    pfn_multi_chan_buffer #(
        .NUM_CH        (NCH),
        .NUM_ENTRIES   (NE),
        .ENTRY_WIDTH   (EW),
        .OVF_CNT_WIDTH (OW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mode_wrap    (mode_wrap),
        .wr_en        (wr_en),
        .pfn_addr_i   (pfn_addr_i),
        .wr_idx_rst   (wr_idx_rst),
        .ovf_clr      (ovf_clr),
        .rd_req       (rd_req),
        .rd_ch        (rd_ch),
        .rd_idx       (rd_idx),
        .rd_valid_o   (rd_valid_o),
        .rd_data_o    (rd_data_o),
        .wr_ptr_o     (wr_ptr_o),
        .wr_cnt_o     (wr_cnt_o),
        .full_o       (full_o),
        .wrapped_o    (wrapped_o),
        .ovf_sticky_o (ovf_sticky_o),
        .ovf_cnt_o    (ovf_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Model: each channel is its count of accepted writes since the last pointer clear,
    // plus an image of what was written where; read results are scheduled by due cycle.
    int            hist [NCH];
    int            ovf  [NCH];
    bit            sticky [NCH];
    logic [EW-1:0] ram [NCH][NE];
    typedef struct { int due; logic [EW-1:0] data; } rd_t;
    rd_t           rdq [$];
    logic [EW-1:0] last_rd;
    int            cyc = 0;
    bit            live = 0;

    function automatic pfn_chan_status_t model_status(input int ch);
        pfn_chan_status_t s;
        s.wr_ptr     = 32'(hist[ch] % NE);
        s.wr_cnt     = 32'((hist[ch] < NE) ? hist[ch] : NE);
        s.full       = (hist[ch] >= NE);
        s.wrapped    = (hist[ch] > NE);
        s.ovf_sticky = sticky[ch];
        s.ovf_cnt    = 32'(ovf[ch]);
        return s;
    endfunction

    task automatic model_step();
        bit evt;
        cyc++;
        if (!reset_n) begin
            live = 1;
            for (int c = 0; c < NCH; c++) begin
                hist[c] = 0; ovf[c] = 0; sticky[c] = 0;
            end
            rdq.delete();
            last_rd = '0;
            return;
        end
        if (!live) return;
        if (rd_req) rdq.push_back('{cyc + 1, ram[rd_ch][rd_idx]});
        for (int c = 0; c < NCH; c++) begin
            evt = 0;
            if (wr_idx_rst[c]) hist[c] = 0;
            if (wr_en[c]) begin
                if (hist[c] < NE || mode_wrap) begin
                    ram[c][hist[c] % NE] = pfn_addr_i[c];
                    if (hist[c] >= NE) evt = 1;
                    hist[c]++;
                end else begin
                    evt = 1;
                end
            end
            if (ovf_clr[c]) begin
                ovf[c] = evt ? 1 : 0;
                sticky[c] = evt;
            end else if (evt) begin
                sticky[c] = 1;
                if (ovf[c] < (1 << OW) - 1) ovf[c]++;
            end
        end
    endtask

    task automatic compare_all();
        pfn_chan_status_t s;
        for (int c = 0; c < NCH; c++) begin
            s = model_status(c);
            check($sformatf("cyc%0d ch%0d wr_ptr", cyc, c), 64'(wr_ptr_o[c]), 64'(s.wr_ptr));
            check($sformatf("cyc%0d ch%0d wr_cnt", cyc, c), 64'(wr_cnt_o[c]), 64'(s.wr_cnt));
            check($sformatf("cyc%0d ch%0d full", cyc, c), 64'(full_o[c]), 64'(s.full));
            check($sformatf("cyc%0d ch%0d wrapped", cyc, c), 64'(wrapped_o[c]), 64'(s.wrapped));
            check($sformatf("cyc%0d ch%0d ovf_sticky", cyc, c), 64'(ovf_sticky_o[c]), 64'(s.ovf_sticky));
            check($sformatf("cyc%0d ch%0d ovf_cnt", cyc, c), 64'(ovf_cnt_o[c]), 64'(s.ovf_cnt));
        end
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            check($sformatf("cyc%0d rd_valid", cyc), 64'(rd_valid_o), 64'(1));
            check($sformatf("cyc%0d rd_data", cyc), 64'(rd_data_o), 64'(rdq[0].data));
            last_rd = rdq[0].data;
            void'(rdq.pop_front());
        end else begin
            check($sformatf("cyc%0d rd_valid idle", cyc), 64'(rd_valid_o), 64'(0));
            check($sformatf("cyc%0d rd_data hold", cyc), 64'(rd_data_o), 64'(last_rd));
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (live) compare_all();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input int ch, input logic [EW-1:0] d);
        wr_en[ch] = 1'b1;
        pfn_addr_i[ch] = d;
        tick();
        wr_en[ch] = 1'b0;
    endtask

    task automatic rd_expect(input int ch, input int idx, input logic [EW-1:0] exp, input string name);
        rd_req = 1'b1;
        rd_ch  = CW'(ch);
        rd_idx = IW'(idx);
        tick();
        rd_req = 1'b0;
        check({name, " valid@1"}, 64'(rd_valid_o), 64'(0));
        tick();
        check({name, " valid@2"}, 64'(rd_valid_o), 64'(1));
        check({name, " data"}, 64'(rd_data_o), 64'(exp));
    endtask

    initial begin
        pfn_chan_status_t ms;
        reset_n    = 1'b0;
        mode_wrap  = 1'b0;
        wr_en      = '0;
        pfn_addr_i = '0;
        wr_idx_rst = '0;
        ovf_clr    = '0;
        rd_req     = 1'b0;
        rd_ch      = '0;
        rd_idx     = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("reset ch%0d wr_cnt", c), 64'(wr_cnt_o[c]), 64'(0));
            check($sformatf("reset ch%0d ovf_cnt", c), 64'(ovf_cnt_o[c]), 64'(0));
        end
        check("reset rd_data", 64'(rd_data_o), 64'(0));

        // Fill and stop
        mode_wrap = 1'b0;
        for (int i = 0; i < 10; i++) wr(0, 32'h100 + 32'(i));
        check("t1 wr_cnt", 64'(wr_cnt_o[0]), 64'(8));
        check("t1 full", 64'(full_o[0]), 64'(1));
        check("t1 ovf_cnt", 64'(ovf_cnt_o[0]), 64'(2));
        check("t1 ovf_sticky", 64'(ovf_sticky_o[0]), 64'(1));
        check("t1 wr_ptr", 64'(wr_ptr_o[0]), 64'(0));
        ms = model_status(0);
        check("t1 model ovf_cnt", 64'(ms.ovf_cnt), 64'(2));
        for (int i = 0; i < 8; i++) begin
            rd_req = 1'b1; rd_ch = '0; rd_idx = IW'(i);
            tick();
        end
        rd_req = 1'b0;
        repeat (2) tick();
        rd_expect(0, 5, 32'h105, "t1 idx5");

        // Ring
        mode_wrap = 1'b1;
        for (int i = 0; i < 11; i++) wr(1, 32'h200 + 32'(i));
        check("t2 wr_ptr", 64'(wr_ptr_o[1]), 64'(3));
        check("t2 wr_cnt", 64'(wr_cnt_o[1]), 64'(8));
        check("t2 wrapped", 64'(wrapped_o[1]), 64'(1));
        check("t2 ovf_cnt", 64'(ovf_cnt_o[1]), 64'(3));
        ms = model_status(1);
        check("t2 model wr_ptr", 64'(ms.wr_ptr), 64'(3));
        rd_expect(1, 0, 32'h208, "t2 idx0");
        rd_expect(1, 2, 32'h20A, "t2 idx2");
        rd_expect(1, 3, 32'h203, "t2 idx3");

        // Simultaneous pointer clear and write on a full channel
        wr_idx_rst[0] = 1'b1;
        wr(0, 32'hABC);
        wr_idx_rst[0] = 1'b0;
        check("t3 wr_ptr", 64'(wr_ptr_o[0]), 64'(1));
        check("t3 wr_cnt", 64'(wr_cnt_o[0]), 64'(1));
        check("t3 ovf_cnt", 64'(ovf_cnt_o[0]), 64'(2));
        check("t3 wrapped", 64'(wrapped_o[0]), 64'(0));
        rd_expect(0, 0, 32'hABC, "t3 idx0");

        // Parallel writes with interleaved reads (same-slot reads see old data)
        wr_idx_rst = 2'b11;
        tick();
        wr_idx_rst = 2'b00;
        for (int i = 0; i < 4; i++) begin
            wr_en = 2'b11;
            pfn_addr_i[0] = 32'h10 + 32'(i);
            pfn_addr_i[1] = 32'h20 + 32'(i);
            rd_req = 1'b1; rd_ch = CW'(i % 2); rd_idx = IW'(i);
            tick();
        end
        wr_en = 2'b00;
        for (int i = 0; i < 8; i++) begin
            rd_req = 1'b1; rd_ch = CW'(i % 2); rd_idx = IW'(i / 2);
            tick();
        end
        rd_req = 1'b0;
        repeat (2) tick();
        check("t4 ch0 wr_cnt", 64'(wr_cnt_o[0]), 64'(4));
        check("t4 ch1 wr_cnt", 64'(wr_cnt_o[1]), 64'(4));
        rd_expect(1, 2, 32'h22, "t4 ch1 idx2");
        rd_expect(0, 3, 32'h13, "t4 ch0 idx3");

        // Counter saturation, mode change while full, clear coinciding with a drop
        mode_wrap = 1'b0;
        ovf_clr[0] = 1'b1;
        tick();
        ovf_clr[0] = 1'b0;
        check("t5 ovf_cnt cleared", 64'(ovf_cnt_o[0]), 64'(0));
        check("t5 sticky cleared", 64'(ovf_sticky_o[0]), 64'(0));
        for (int i = 0; i < 4; i++) wr(0, 32'h300 + 32'(i));
        for (int i = 0; i < 20; i++) wr(0, 32'h400 + 32'(i));
        check("t5 ovf_cnt sat", 64'(ovf_cnt_o[0]), 64'(15));
        mode_wrap = 1'b1;
        tick();
        check("t5 mode chg wr_cnt", 64'(wr_cnt_o[0]), 64'(8));
        check("t5 mode chg wr_ptr", 64'(wr_ptr_o[0]), 64'(0));
        mode_wrap = 1'b0;
        ovf_clr[0] = 1'b1;
        wr(0, 32'h500);
        ovf_clr[0] = 1'b0;
        check("t5 clr+drop ovf_cnt", 64'(ovf_cnt_o[0]), 64'(1));
        check("t5 clr+drop sticky", 64'(ovf_sticky_o[0]), 64'(1));
        rd_expect(0, 0, 32'h10, "t5 idx0 not overwritten");
        rd_expect(0, 4, 32'h300, "t5 idx4");

        // Reset with a read in flight
        wr_idx_rst[0] = 1'b1;
        tick();
        wr_idx_rst[0] = 1'b0;
        for (int i = 0; i < 5; i++) wr(0, 32'h600 + 32'(i));
        check("t6 wr_cnt", 64'(wr_cnt_o[0]), 64'(5));
        rd_req = 1'b1; rd_ch = '0; rd_idx = IW'(2);
        tick();
        rd_req = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t6 rd_valid after reset", 64'(rd_valid_o), 64'(0));
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("t6 ch%0d wr_cnt", c), 64'(wr_cnt_o[c]), 64'(0));
            check($sformatf("t6 ch%0d wr_ptr", c), 64'(wr_ptr_o[c]), 64'(0));
            check($sformatf("t6 ch%0d sticky", c), 64'(ovf_sticky_o[c]), 64'(0));
            check($sformatf("t6 ch%0d wrapped", c), 64'(wrapped_o[c]), 64'(0));
        end
        tick();
        check("t6 rd_valid next", 64'(rd_valid_o), 64'(0));
        check("t6 rd_data", 64'(rd_data_o), 64'(0));
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
